// File: rtl/tx_packet_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX stream.
// Optional mid-packet starvation watchdog: define ARB_WATCHDOG_EN.
package uart_pkg;

  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
  } UART_PACKET;

endpackage

module tx_packet_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 8
`ifdef ARB_WATCHDOG_EN
  ,
  parameter int WATCHDOG_CYCLES = 1024
`endif
) (
  input  logic                     ipClk,
  input  logic                     reset,
  input  UART_PACKET [NUM_REQ-1:0] ipRxStreams,
  input  logic                     ipTxReady,
  output UART_PACKET               opTxStream,
  output logic [NUM_REQ-1:0]       opGrant,
  output logic [NUM_REQ-1:0]       opOverflow,
  output logic [NUM_REQ-1:0]       opFramingError
`ifdef ARB_WATCHDOG_EN
  ,
  output logic [NUM_REQ-1:0]       opTimeout
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 34;

  typedef logic [EW-1:0] entry_t;
  typedef logic [AW:0]   ptr_t;
  typedef enum logic {IDLE, STREAM} state_t;

  entry_t mem_q [NUM_REQ][FIFO_DEPTH];
  ptr_t [NUM_REQ-1:0] wr_q, wr_d;
  ptr_t [NUM_REQ-1:0] rd_q, rd_d;

  state_t             state_q, state_d;
  UART_PACKET         out_q, out_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] ovf_q, ovf_d;
  logic [NUM_REQ-1:0] ferr_q, ferr_d;

  logic [NUM_REQ-1:0] empty, full, sop_head;
  logic [NUM_REQ-1:0] push, pop, drop;
  logic [NUM_REQ-1:0] flush, discard;
  entry_t             head [NUM_REQ];
  logic               win_vld;
  logic [IW-1:0]      win_idx;
  logic               xfer;
  logic               wd_fire;

  assign xfer = out_q.Valid && ipTxReady;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      empty[i] = wr_q[i] == rd_q[i];
      full[i] = (wr_q[i][AW] != rd_q[i][AW]) &&
                (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
      head[i] = mem_q[i][rd_q[i][AW-1:0]];
      sop_head[i] = head[i][EW-1];
      discard[i] = (state_q == IDLE) && !empty[i] &&
                   !sop_head[i];
    end
  end

  // First SoP head found after the last owner wins.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && !empty[idx] && sop_head[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    pop     = discard;
    flush   = '0;
    if (xfer) out_d = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          pop[win_idx]     = 1'b1;
          out_d            = {1'b1, head[win_idx]};
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          state_d          = STREAM;
        end
      end
      STREAM: begin
        if (xfer && out_q.EoP) begin
          rr_d    = gidx_q;
          grant_d = '0;
          state_d = IDLE;
        end else if (wd_fire) begin
          flush[gidx_q] = 1'b1;
          rr_d          = gidx_q;
          grant_d       = '0;
          state_d       = IDLE;
        end else if ((!out_q.Valid || xfer) &&
                     !empty[gidx_q]) begin
          pop[gidx_q] = 1'b1;
          out_d       = {1'b1, head[gidx_q]};
        end
      end
    endcase
  end

  // A full FIFO still takes a push when it pops the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      push[i] = ipRxStreams[i].Valid && (!full[i] || pop[i]);
      drop[i] = ipRxStreams[i].Valid && full[i] && !pop[i];
      wr_d[i] = wr_q[i] + ptr_t'(push[i]);
      rd_d[i] = flush[i] ? wr_q[i] : rd_q[i] + ptr_t'(pop[i]);
    end
  end

  assign ovf_d  = ovf_q | drop;
  assign ferr_d = ferr_q | discard;

  always_ff @(posedge ipClk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      ovf_q   <= '0;
      ferr_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge ipClk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        mem_q[i][wr_q[i][AW-1:0]] <= {
          ipRxStreams[i].SoP,
          ipRxStreams[i].EoP,
          ipRxStreams[i].Source,
          ipRxStreams[i].Destination,
          ipRxStreams[i].Length,
          ipRxStreams[i].Data
        };
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WW-1:0]      wd_q, wd_d;
  logic [NUM_REQ-1:0] tmo_q, tmo_d;
  logic               starve;

  assign starve = (state_q == STREAM) && empty[gidx_q] &&
                  !out_q.Valid;
  assign wd_fire = starve &&
                   (wd_q == WW'(WATCHDOG_CYCLES - 1));
  assign wd_d = (starve && !wd_fire) ? wd_q + WW'(1) : '0;
  assign tmo_d = tmo_q | (wd_fire ? grant_q : '0);

  always_ff @(posedge ipClk) begin
    if (reset) begin
      wd_q  <= '0;
      tmo_q <= '0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign opTimeout = tmo_q;
`else
  assign wd_fire = 1'b0;
`endif

  assign opTxStream     = out_q;
  assign opGrant        = grant_q;
  assign opOverflow     = ovf_q;
  assign opFramingError = ferr_q;

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Directed bench for tx_packet_arbiter at NUM_REQ=2, FIFO_DEPTH=8.
// Each task drives a scenario cycle by cycle against hand-built expectations.
module tb_tx_packet_arbiter;
  import uart_pkg::*;

  logic             ipClk = 1'b0;
  logic             reset;
  UART_PACKET [1:0] rx;
  logic             rdy;
  UART_PACKET       tx;
  logic [1:0]       gnt, ovf, ferr;
`ifdef ARB_WATCHDOG_EN
  logic [1:0]       tmo;
`endif
  int vecs = 0;
  int errs = 0;

  always #5 ipClk = ~ipClk;

  tx_packet_arbiter dut (
    .ipClk          (ipClk),
    .reset          (reset),
    .ipRxStreams    (rx),
    .ipTxReady      (rdy),
    .opTxStream     (tx),
    .opGrant        (gnt),
    .opOverflow     (ovf),
    .opFramingError (ferr)
`ifdef ARB_WATCHDOG_EN
    ,
    .opTimeout      (tmo)
`endif
  );

  function automatic UART_PACKET mk(input logic s, input logic e,
                                    input logic [7:0] src,
                                    input logic [7:0] dat);
    UART_PACKET p;
    p.Valid       = 1'b1;
    p.SoP         = s;
    p.EoP         = e;
    p.Source      = src;
    p.Destination = 8'h01;
    p.Length      = 8'h04;
    p.Data        = dat;
    return p;
  endfunction

  task automatic cyc();
    @(posedge ipClk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = '0;
    rdy   = 1'b0;
    cyc();
    cyc();
    vecs++;
    if (tx !== '0) begin
      errs++;
      $display("FAIL reset_tx: got %h want 0", tx);
    end
    vecs++;
    if (gnt !== 2'b00) begin
      errs++;
      $display("FAIL reset_grant: got %b want 00", gnt);
    end
    vecs++;
    if (ovf !== 2'b00) begin
      errs++;
      $display("FAIL reset_ovf: got %b want 00", ovf);
    end
    vecs++;
    if (ferr !== 2'b00) begin
      errs++;
      $display("FAIL reset_ferr: got %b want 00", ferr);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single(input string tag);
    logic [7:0] d [4];
    logic ev, es, ee;
    logic [7:0] ed;
    logic [1:0] eg;
    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rx = '0;
      if (c < 4) rx[0] = mk(c == 0, c == 3, 8'h00, d[c]);
      ev = (c >= 2) && (c <= 5);
      es = (c == 2);
      ee = (c == 5);
      ed = 8'h00;
      if (ev) ed = d[c-2];
      eg = ev ? 2'b01 : 2'b00;
      vecs++;
      if (tx.Valid !== ev || gnt !== eg ||
          (ev && {tx.SoP, tx.EoP, tx.Data} !== {es, ee, ed})) begin
        errs++;
        $display("FAIL %s c%0d: got v=%b s=%b e=%b d=%h g=%b, want v=%b s=%b e=%b d=%h g=%b",
                 tag, c, tx.Valid, tx.SoP, tx.EoP, tx.Data, gnt,
                 ev, es, ee, ed, eg);
      end
      cyc();
    end
  endtask

  task automatic test_stray();
    rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rx = '0;
      if (c == 0) rx[0] = mk(1'b0, 1'b0, 8'h00, 8'h33);
      vecs++;
      if (tx.Valid !== 1'b0 || gnt !== 2'b00) begin
        errs++;
        $display("FAIL stray_out c%0d: got v=%b g=%b, want v=0 g=00",
                 c, tx.Valid, gnt);
      end
      if (c == 1) begin
        vecs++;
        if (ferr !== 2'b00) begin
          errs++;
          $display("FAIL stray_ferr_pre: got %b want 00", ferr);
        end
      end
      if (c == 3) begin
        vecs++;
        if (ferr !== 2'b01) begin
          errs++;
          $display("FAIL stray_ferr: got %b want 01", ferr);
        end
      end
      cyc();
    end
  endtask

  task automatic test_overflow();
    logic ev, es, ee;
    logic [7:0] ed;
    logic [1:0] eg;
    for (int c = 0; c < 26; c++) begin
      rx  = '0;
      rdy = (c >= 12);
      if (c == 0)  rx[0] = mk(1'b1, 1'b0, 8'h00, 8'h50);
      if (c == 13) rx[0] = mk(1'b0, 1'b1, 8'h00, 8'h51);
      if (c >= 1 && c <= 10)
        rx[1] = mk(c == 1, c == 8, 8'h01, 8'(8'h5F + c));
      ev = 1'b0; es = 1'b0; ee = 1'b0; ed = 8'h00; eg = 2'b00;
      if (c >= 2 && c <= 12) begin
        ev = 1'b1; es = 1'b1; ed = 8'h50; eg = 2'b01;
      end else if (c == 13 || c == 14) begin
        eg = 2'b01;
      end else if (c == 15) begin
        ev = 1'b1; ee = 1'b1; ed = 8'h51; eg = 2'b01;
      end else if (c >= 17 && c <= 24) begin
        ev = 1'b1; es = (c == 17); ee = (c == 24);
        ed = 8'(8'h60 + c - 17); eg = 2'b10;
      end
      vecs++;
      if (tx.Valid !== ev || gnt !== eg ||
          (ev && {tx.SoP, tx.EoP, tx.Data} !== {es, ee, ed})) begin
        errs++;
        $display("FAIL overflow c%0d: got v=%b s=%b e=%b d=%h g=%b, want v=%b s=%b e=%b d=%h g=%b",
                 c, tx.Valid, tx.SoP, tx.EoP, tx.Data, gnt,
                 ev, es, ee, ed, eg);
      end
      if (c == 9) begin
        vecs++;
        if (ovf !== 2'b00) begin
          errs++;
          $display("FAIL overflow_flag_pre: got %b want 00", ovf);
        end
      end
      if (c == 25) begin
        vecs++;
        if (ovf !== 2'b10) begin
          errs++;
          $display("FAIL overflow_flag: got %b want 10", ovf);
        end
      end
      cyc();
    end
  endtask

  task automatic test_contention(input int w, input string tag);
    logic ev, es, ee;
    logic [7:0] ed;
    logic [1:0] eg;
    int who, k;
    rdy = 1'b1;
    for (int c = 0; c < 13; c++) begin
      rx = '0;
      if (c < 4) begin
        rx[0] = mk(c == 0, c == 3, 8'h00, 8'(8'h10 + c));
        rx[1] = mk(c == 0, c == 3, 8'h01, 8'(8'h20 + c));
      end
      ev = 1'b0; es = 1'b0; ee = 1'b0; ed = 8'h00; eg = 2'b00;
      who = 0; k = 0;
      if (c >= 2 && c <= 5) begin
        ev = 1'b1; who = w; k = c - 2;
      end else if (c >= 7 && c <= 10) begin
        ev = 1'b1; who = 1 - w; k = c - 7;
      end
      if (ev) begin
        es = (k == 0);
        ee = (k == 3);
        ed = 8'(16 * (who + 1) + k);
        eg = 2'(1 << who);
      end
      vecs++;
      if (tx.Valid !== ev || gnt !== eg ||
          (ev && {tx.SoP, tx.EoP, tx.Data} !== {es, ee, ed})) begin
        errs++;
        $display("FAIL %s c%0d: got v=%b s=%b e=%b d=%h g=%b, want v=%b s=%b e=%b d=%h g=%b",
                 tag, c, tx.Valid, tx.SoP, tx.EoP, tx.Data, gnt,
                 ev, es, ee, ed, eg);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int bi [11];
    logic ev, es, ee;
    logic [7:0] ed;
    logic [1:0] eg;
    bi = '{-1, -1, 0, 1, 1, 2, 2, 3, 3, -1, -1};
    for (int c = 0; c < 11; c++) begin
      rx  = '0;
      rdy = (c % 2 == 0);
      if (c < 4) rx[0] = mk(c == 0, c == 3, 8'h00, 8'(8'hA0 + c));
      ev = (bi[c] >= 0);
      es = (bi[c] == 0);
      ee = (bi[c] == 3);
      ed = ev ? 8'(8'hA0 + bi[c]) : 8'h00;
      eg = ev ? 2'b01 : 2'b00;
      vecs++;
      if (tx.Valid !== ev || gnt !== eg ||
          (ev && {tx.SoP, tx.EoP, tx.Data} !== {es, ee, ed})) begin
        errs++;
        $display("FAIL backpressure c%0d: got v=%b s=%b e=%b d=%h g=%b, want v=%b s=%b e=%b d=%h g=%b",
                 c, tx.Valid, tx.SoP, tx.EoP, tx.Data, gnt,
                 ev, es, ee, ed, eg);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rx = '0;
      if (c < 4) rx[0] = mk(c == 0, c == 3, 8'h00, 8'(8'h70 + c));
      if (c >= 2) begin
        vecs++;
        if (tx.Valid !== 1'b1 || gnt !== 2'b01 ||
            tx.Data !== 8'(8'h6E + c)) begin
          errs++;
          $display("FAIL reset_mid_pre c%0d: got v=%b d=%h g=%b, want v=1 d=%h g=01",
                   c, tx.Valid, tx.Data, gnt, 8'(8'h6E + c));
        end
      end
      if (c == 4) reset = 1'b1;
      cyc();
    end
    reset = 1'b0;
    for (int c = 5; c < 9; c++) begin
      vecs++;
      if (tx.Valid !== 1'b0 || gnt !== 2'b00) begin
        errs++;
        $display("FAIL reset_mid_out c%0d: got v=%b g=%b, want v=0 g=00",
                 c, tx.Valid, gnt);
      end
      if (c == 5 || c == 8) begin
        vecs++;
        if (ovf !== 2'b00 || ferr !== 2'b00) begin
          errs++;
          $display("FAIL reset_mid_flags c%0d: got ovf=%b ferr=%b, want 00 00",
                   c, ovf, ferr);
        end
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_stray();
    test_overflow();
    test_contention(0, "contention_rr1");
    test_backpressure();
    test_reset_mid();
    test_single("after_reset");
    test_contention(1, "contention_rr0");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
